// File: rtl/lcd_pkg.sv
// ---------------------------------------------------------------------------
// lcd_pkg
// Shared definitions for the two-requester LCD bus arbiter:
//   - lcd_state_t   : FSM state encoding (INIT exists only with LCD_ARB_INIT_EN)
//   - INIT_CMD_*    : power-up command bytes (only with LCD_ARB_INIT_EN)
//   - CLR_HOME_MASK : bits that must be zero (with rs=0) for clear/home
//   - is_clear_home : long-settle command detect
//   - max_int / cnt_width : helpers for sizing the phase counter
// Optional feature macro: LCD_ARB_INIT_EN
// ---------------------------------------------------------------------------
package lcd_pkg;

    typedef enum logic [2:0] {
`ifdef LCD_ARB_INIT_EN
        ST_INIT  = 3'd0,
`endif
        ST_IDLE  = 3'd1,
        ST_SETUP = 3'd2,
        ST_PULSE = 3'd3,
        ST_HOLD  = 3'd4,
        ST_WAIT  = 3'd5
    } lcd_state_t;

`ifdef LCD_ARB_INIT_EN
    // Power-up sequence: 8-bit/2-line, display on, entry mode, clear.
    localparam logic [7:0] INIT_CMD_FUNC_SET = 8'h38;
    localparam logic [7:0] INIT_CMD_DISP_ON  = 8'h0C;
    localparam logic [7:0] INIT_CMD_ENTRY    = 8'h06;
    localparam logic [7:0] INIT_CMD_CLEAR    = 8'h01;
    localparam logic [1:0] INIT_LAST_IDX     = 2'd3;
`endif

    // Clear (0x01) and home (0x02/0x03) are the only commands with dat[7:2]==0.
    localparam logic [7:0] CLR_HOME_MASK = 8'hFC;

    function automatic logic is_clear_home(input logic rs, input logic [7:0] dat);
        return (rs == 1'b0) && ((dat & CLR_HOME_MASK) == 8'h00);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Smallest width (at least 1) that represents max_val without wrap.
    function automatic int cnt_width(input int max_val);
        int w;
        w = 1;
        while ((1 << w) <= max_val) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// ---------------------------------------------------------------------------
// lcd_phase_timer
// Loadable down-counter shared by every FSM phase. Loading N-1 on the edge
// that enters a phase makes done rise after N cycles in that phase.
// Ports:
//   clk      : clock (rising edge)
//   reset    : synchronous active-high reset, clears the count
//   load     : load load_val this edge (takes priority over counting)
//   load_val : phase length minus one
//   done     : count has reached zero
// ---------------------------------------------------------------------------
module lcd_phase_timer #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - W'(1);
        end
    end

    assign done = (count_reg == '0);

endmodule

// File: rtl/lcd_bus_arbiter.sv
// ---------------------------------------------------------------------------
// lcd_bus_arbiter
// Round-robin arbiter giving two requesters write access to an HD44780-style
// 8-bit LCD bus, generating setup / enable pulse / hold / settle timing.
// Optional feature macro: LCD_ARB_INIT_EN -- when defined the block starts in
// INIT and issues 0x38, 0x0C, 0x06, 0x01 before serving any requester.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   req0/req1             : write requests (held until gnt)
//   rs0/rs1, dat0/dat1    : register select and byte from each requester
//   gnt0/gnt1             : one-cycle accept pulse
//   lcd_rs/lcd_rw/lcd_en  : LCD control lines (lcd_rw tied low)
//   lcd_dat               : LCD data byte, held between writes
//   busy                  : high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module lcd_bus_arbiter #(
    parameter int TSU        = 2,
    parameter int TPW        = 4,
    parameter int THD        = 2,
    parameter int TWAIT      = 20,
    parameter int TWAIT_LONG = 800
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    input  logic       rs0,
    input  logic       rs1,
    input  logic [7:0] dat0,
    input  logic [7:0] dat1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic [7:0] lcd_dat,
    output logic       busy
);

    import lcd_pkg::*;

    // Counter holds the longest phase length minus one.
    localparam int CNT_MAX = max_int(max_int(max_int(TSU, TPW), THD),
                                     max_int(TWAIT, TWAIT_LONG)) - 1;
    localparam int CNT_W   = cnt_width(CNT_MAX);

    localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(TSU - 1);
    localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(TPW - 1);
    localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(THD - 1);
    localparam logic [CNT_W-1:0] LD_WAIT  = CNT_W'(TWAIT - 1);
    localparam logic [CNT_W-1:0] LD_LONG  = CNT_W'(TWAIT_LONG - 1);

    lcd_state_t       state_reg;
    lcd_state_t       state_next;
    logic             timer_load;
    logic [CNT_W-1:0] timer_val;
    logic             timer_done;

    logic [1:0]       req_vec;
    logic [1:0]       rs_vec;
    logic [1:0][7:0]  dat_vec;
    logic             win_idx;
    logic             grant_fire;
    logic             last_reg;
    logic [1:0]       gnt_next;
    logic [1:0]       gnt_reg;
    logic             lcd_rs_reg;
    logic [7:0]       lcd_dat_reg;

    assign req_vec    = {req1, req0};
    assign rs_vec     = {rs1, rs0};
    assign dat_vec[0] = dat0;
    assign dat_vec[1] = dat1;

    // On a tie the requester not served last wins; a lone requester always wins.
    assign win_idx    = (req_vec == 2'b11) ? ~last_reg : req_vec[1];
    assign grant_fire = (state_reg == ST_IDLE) && (req_vec != 2'b00);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_gnt
            assign gnt_next[gi] = grant_fire && (win_idx == 1'(gi));
        end
    endgenerate

    lcd_phase_timer #(
        .W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val (timer_val),
        .done     (timer_done)
    );

`ifdef LCD_ARB_INIT_EN
    // Power-up command ROM and sequencing.
    logic [1:0] init_idx_reg;
    logic       init_pending_reg;
    logic [7:0] init_cmd;

    always_comb begin
        case (init_idx_reg)
            2'd0:    init_cmd = INIT_CMD_FUNC_SET;
            2'd1:    init_cmd = INIT_CMD_DISP_ON;
            2'd2:    init_cmd = INIT_CMD_ENTRY;
            default: init_cmd = INIT_CMD_CLEAR;
        endcase
    end

    // pending drops when the last command is issued so its WAIT returns to IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            init_idx_reg     <= 2'd0;
            init_pending_reg <= 1'b1;
        end else if (state_reg == ST_INIT) begin
            init_idx_reg <= init_idx_reg + 2'd1;
            if (init_idx_reg == INIT_LAST_IDX) begin
                init_pending_reg <= 1'b0;
            end
        end
    end
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
`ifdef LCD_ARB_INIT_EN
            state_reg <= ST_INIT;
`else
            state_reg <= ST_IDLE;
`endif
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next state; the timer is reloaded on every phase entry.
    always_comb begin
        state_next = state_reg;
        timer_load = 1'b0;
        timer_val  = '0;
        unique case (state_reg)
`ifdef LCD_ARB_INIT_EN
            ST_INIT: begin
                state_next = ST_SETUP;
                timer_load = 1'b1;
                timer_val  = LD_SETUP;
            end
`endif
            ST_IDLE: begin
                if (grant_fire) begin
                    state_next = ST_SETUP;
                    timer_load = 1'b1;
                    timer_val  = LD_SETUP;
                end
            end
            ST_SETUP: begin
                if (timer_done) begin
                    state_next = ST_PULSE;
                    timer_load = 1'b1;
                    timer_val  = LD_PULSE;
                end
            end
            ST_PULSE: begin
                if (timer_done) begin
                    state_next = ST_HOLD;
                    timer_load = 1'b1;
                    timer_val  = LD_HOLD;
                end
            end
            ST_HOLD: begin
                if (timer_done) begin
                    state_next = ST_WAIT;
                    timer_load = 1'b1;
                    // Bus registers still carry the byte just written.
                    timer_val  = is_clear_home(lcd_rs_reg, lcd_dat_reg) ? LD_LONG : LD_WAIT;
                end
            end
            ST_WAIT: begin
                if (timer_done) begin
`ifdef LCD_ARB_INIT_EN
                    state_next = init_pending_reg ? ST_INIT : ST_IDLE;
`else
                    state_next = ST_IDLE;
`endif
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // FSM outputs.
    always_comb begin
        lcd_en = (state_reg == ST_PULSE);
        busy   = (state_reg != ST_IDLE);
        lcd_rw = 1'b0;
        gnt0   = gnt_reg[0];
        gnt1   = gnt_reg[1];
    end

    // Bus data, grant pulses and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            lcd_rs_reg  <= 1'b0;
            lcd_dat_reg <= 8'h00;
            last_reg    <= 1'b1;
            gnt_reg     <= 2'b00;
        end else begin
            gnt_reg <= gnt_next;
            if (grant_fire) begin
                lcd_rs_reg  <= rs_vec[win_idx];
                lcd_dat_reg <= dat_vec[win_idx];
                last_reg    <= win_idx;
            end
`ifdef LCD_ARB_INIT_EN
            else if (state_reg == ST_INIT) begin
                lcd_rs_reg  <= 1'b0;
                lcd_dat_reg <= init_cmd;
            end
`endif
        end
    end

    assign lcd_rs  = lcd_rs_reg;
    assign lcd_dat = lcd_dat_reg;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_lcd_bus_arbiter
// Bench for lcd_bus_arbiter. A cycle-level reference model (negedge) decides
// grants from the arbitration rules, tracks remaining busy time as a plain
// count, and queues each expected LCD write; a separate bus monitor pops the
// queue on every lcd_en rising edge and checks byte, rs, setup and width.
// Honours LCD_ARB_INIT_EN when the design is built with it.
// ---------------------------------------------------------------------------
module tb_lcd_bus_arbiter;

    localparam int TSU        = 2;
    localparam int TPW        = 4;
    localparam int THD        = 2;
    localparam int TWAIT      = 20;
    localparam int TWAIT_LONG = 800;
    localparam int BASE       = TSU + TPW + THD;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1, rs0, rs1;
    logic [7:0] dat0, dat1;
    logic       gnt0, gnt1, lcd_rs, lcd_rw, lcd_en, busy;
    logic [7:0] lcd_dat;

    always #5 clk = ~clk;

    lcd_bus_arbiter #(
        .TSU        (TSU),
        .TPW        (TPW),
        .THD        (THD),
        .TWAIT      (TWAIT),
        .TWAIT_LONG (TWAIT_LONG)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req0    (req0),
        .req1    (req1),
        .rs0     (rs0),
        .rs1     (rs1),
        .dat0    (dat0),
        .dat1    (dat1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .lcd_rs  (lcd_rs),
        .lcd_rw  (lcd_rw),
        .lcd_en  (lcd_en),
        .lcd_dat (lcd_dat),
        .busy    (busy)
    );

    int tests    = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       rs;
        logic [7:0] dat;
        int         gcyc;
    } exp_t;

    exp_t exp_q[$];

`ifdef LCD_ARB_INIT_EN
    logic [7:0] init_cmds [4] = '{8'h38, 8'h0C, 8'h06, 8'h01};
    localparam int RST_BUSY = 1;
`else
    localparam int RST_BUSY = 0;
`endif

    task automatic chk(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    int         left    = 0;
    int         exp_gnt = -1;
    logic       last    = 1'b1;
    logic       last_rs = 1'b0;
    logic [7:0] last_dat = 8'h00;
    logic       m_w;
    logic       m_rs;
    logic [7:0] m_dat;

    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            exp_gnt = -1;
            last    = 1'b1;
            last_rs = 1'b0;
`ifdef LCD_ARB_INIT_EN
            // Each init command: one INIT cycle plus the normal write timing.
            left     = 4 * (1 + BASE) + 3 * TWAIT + TWAIT_LONG;
            last_dat = 8'h01;
            for (int j = 0; j < 4; j++)
                exp_q.push_back('{1'b0, init_cmds[j], cyc + 2 + j * (1 + BASE + TWAIT)});
`else
            left     = 0;
            last_dat = 8'h00;
`endif
        end else begin
            chk("busy", busy, int'(left != 0));
            chk("gnt0", gnt0, int'(exp_gnt == 0));
            chk("gnt1", gnt1, int'(exp_gnt == 1));
            if (left == 0) begin
                chk("hold_dat", lcd_dat, last_dat);
                chk("hold_rs", lcd_rs, last_rs);
            end
            exp_gnt = -1;
            if (left > 0) begin
                left--;
            end else if (req0 || req1) begin
                m_w   = (req0 && req1) ? !last : req1;
                m_rs  = m_w ? rs1 : rs0;
                m_dat = m_w ? dat1 : dat0;
                exp_q.push_back('{m_rs, m_dat, cyc + 1});
                left     = BASE + ((m_rs == 1'b0 && m_dat < 8'd4) ? TWAIT_LONG : TWAIT);
                last     = m_w;
                exp_gnt  = int'(m_w);
                last_rs  = m_rs;
                last_dat = m_dat;
            end
        end
    end

    // ---------------- bus monitor ----------------
    logic rst_d    = 1'b1;
    bit   in_pulse = 1'b0;
    int   rise_cyc = 0;
    exp_t mon_e;

    always @(negedge clk) begin
        if (rst_d) begin
            in_pulse = 1'b0;
            chk("rst_en", lcd_en, 0);
            chk("rst_dat", lcd_dat, 0);
            chk("rst_rs", lcd_rs, 0);
            chk("rst_gnt0", gnt0, 0);
            chk("rst_gnt1", gnt1, 0);
            chk("rst_busy", busy, RST_BUSY);
        end else if (lcd_en && !in_pulse) begin
            in_pulse = 1'b1;
            rise_cyc = cyc;
            if (exp_q.size() == 0) begin
                tests++;
                failures++;
                $display("FAIL unexpected_write: got dat 0x%02h, expected no write (cycle %0d)", lcd_dat, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("write_dat", lcd_dat, mon_e.dat);
                chk("write_rs", lcd_rs, mon_e.rs);
                chk("setup_time", cyc - mon_e.gcyc, TSU);
                chk("rw_low", lcd_rw, 0);
            end
        end else if (!lcd_en && in_pulse) begin
            in_pulse = 1'b0;
            chk("pulse_width", cyc - rise_cyc, TPW);
        end
        rst_d = reset;
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input int i, input int budget);
        for (int n = 0; n < budget; n++) begin
            step();
            if ((i == 0) ? gnt0 : gnt1) return;
        end
        tests++;
        failures++;
        $display("FAIL wait_gnt%0d: got no grant, expected one within %0d cycles", i, budget);
    endtask

    task automatic wait_idle(input int budget);
        for (int n = 0; n < budget; n++) begin
            step();
            if (!busy) return;
        end
        tests++;
        failures++;
        $display("FAIL wait_idle: got busy, expected idle within %0d cycles", budget);
    endtask

    task automatic wait_en(input int budget);
        for (int n = 0; n < budget; n++) begin
            step();
            if (lcd_en) return;
        end
        tests++;
        failures++;
        $display("FAIL wait_en: got no enable, expected one within %0d cycles", budget);
    endtask

    bit         r_req [2];
    bit         r_rs  [2];
    logic [7:0] r_dat [2];
    int         r_idle[2];

    initial begin
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; rs0 = 1'b0; rs1 = 1'b0;
        dat0 = 8'h00; dat1 = 8'h00;
        repeat (4) @(posedge clk);
        #1 reset = 1'b0;

        // Character write from requester 0.
        req0 = 1'b1; rs0 = 1'b1; dat0 = 8'h41;
        wait_gnt(0, 3000);
        req0 = 1'b0;
        wait_idle(3000);

        // Clear command from requester 1 (long settle).
        req1 = 1'b1; rs1 = 1'b0; dat1 = 8'h01;
        wait_gnt(1, 3000);
        req1 = 1'b0;
        wait_idle(3000);

        // Both held: grants must alternate.
        req0 = 1'b1; rs0 = 1'b1; dat0 = 8'h30;
        req1 = 1'b1; rs1 = 1'b1; dat1 = 8'h31;
        repeat (130) step();
        req0 = 1'b0; req1 = 1'b0;
        wait_idle(3000);

        // Reset in the middle of the enable pulse, then a tie.
        req0 = 1'b1; rs0 = 1'b1; dat0 = 8'h55;
        wait_en(3000);
        req0 = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        req0 = 1'b1; rs0 = 1'b1; dat0 = 8'h61;
        req1 = 1'b1; rs1 = 1'b1; dat1 = 8'h62;
        wait_gnt(0, 3000);
        req0 = 1'b0;
        wait_gnt(1, 3000);
        req1 = 1'b0;
        wait_idle(3000);

        // Randomized traffic, including withdrawn requests and clear/home.
        for (int i = 0; i < 2; i++) begin
            r_req[i] = 1'b0; r_rs[i] = 1'b0; r_dat[i] = 8'h00; r_idle[i] = i;
        end
        for (int n = 0; n < 4000; n++) begin
            step();
            for (int i = 0; i < 2; i++) begin
                if ((i == 0) ? gnt0 : gnt1) begin
                    r_req[i]  = 1'b0;
                    r_idle[i] = $urandom_range(0, 6);
                end else if (!r_req[i]) begin
                    if (r_idle[i] == 0) begin
                        r_req[i] = 1'b1;
                        r_rs[i]  = 1'($urandom_range(0, 1));
                        r_dat[i] = 8'($urandom);
                        if ($urandom_range(0, 9) == 0) begin
                            r_rs[i]  = 1'b0;
                            r_dat[i] = 8'($urandom_range(0, 3));
                        end
                    end else begin
                        r_idle[i]--;
                    end
                end else if ($urandom_range(0, 40) == 0) begin
                    r_req[i]  = 1'b0;
                    r_idle[i] = $urandom_range(0, 3);
                end
            end
            req0 = r_req[0]; rs0 = r_rs[0]; dat0 = r_dat[0];
            req1 = r_req[1]; rs1 = r_rs[1]; dat1 = r_dat[1];
        end
        req0 = 1'b0; req1 = 1'b0;
        wait_idle(3000);
        repeat (3) step();
        chk("queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
